// File: rtl/keypad_debouncer.sv
// Debounces the 4x4 keypad scanner output over 4-cycle scan frames and delivers each press once.
// Latency: a press appears on key_valid one cycle after the end of its STABLE_FRAMES-th frame; presses that find the output register full are dropped with an overrun pulse.
module keypad_debouncer #(
  parameter int STABLE_FRAMES = 4
) (
  input  logic       scan_clk,
  input  logic       rst_n,
  input  logic       keydown,
  input  logic [3:0] key,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       held,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

  state_t     state, next_state;
  logic [1:0] fc;
  logic       f_hit, f_multi;
  logic [3:0] f_code;
  logic [3:0] cand, next_cand;
  logic [3:0] cnt, next_cnt;
  logic [3:0] cnt_inc;

  logic       eff_hit, eff_multi;
  logic [3:0] eff_code;
  logic       frame_end, res_none, res_key;
  logic       press, held_next;

  // The current sample is folded in so the counter-3 cycle counts toward its own frame.
  always_comb begin
    eff_hit   = f_hit | keydown;
    eff_code  = f_hit ? f_code : key;
    eff_multi = f_multi | (f_hit & keydown & (key != f_code));
    frame_end = (fc == 2'd3);
    res_none  = ~eff_hit;
    res_key   = eff_hit & ~eff_multi;
    cnt_inc   = cnt + 4'd1;
  end

  always_ff @(posedge scan_clk) begin
    if (!rst_n) begin
      fc      <= 2'd0;
      f_hit   <= 1'b0;
      f_multi <= 1'b0;
      f_code  <= 4'd0;
    end else begin
      fc <= fc + 2'd1;
      if (frame_end) begin
        f_hit   <= 1'b0;
        f_multi <= 1'b0;
        f_code  <= 4'd0;
      end else begin
        f_hit   <= eff_hit;
        f_multi <= eff_multi;
        f_code  <= eff_code;
      end
    end
  end

  always_ff @(posedge scan_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cand  <= next_cand;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cand  = cand;
    next_cnt   = cnt;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_key) begin
            next_state = CONFIRM;
            next_cand  = eff_code;
            next_cnt   = 4'd1;
          end
        end
        CONFIRM: begin
          if (res_key && eff_code == cand) begin
            if (cnt_inc == STABLE) begin
              next_state = HELD;
            end
            next_cnt = cnt_inc;
          end else if (res_key) begin
            next_cand = eff_code;
            next_cnt  = 4'd1;
          end else begin
            next_state = IDLE;
            next_cnt   = 4'd0;
          end
        end
        HELD: begin
          if (res_none) begin
            next_state = RELEASE;
            next_cnt   = 4'd1;
          end
        end
        RELEASE: begin
          if (!res_none) begin
            next_state = HELD;
          end else if (cnt_inc == STABLE) begin
            next_state = IDLE;
            next_cnt   = 4'd0;
          end else begin
            next_cnt = cnt_inc;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    press     = frame_end && (state == CONFIRM) && res_key &&
                (eff_code == cand) && (cnt_inc == STABLE);
    held_next = (next_state == HELD) || (next_state == RELEASE);
  end

  // Single-entry output register; a press only overwrites when the old code leaves this cycle.
  always_ff @(posedge scan_clk) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      held      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      held    <= held_next;
      overrun <= 1'b0;
      if (press) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= cand;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer: expected press codes are queued as stimulus is built and popped on each handshake.
module tb_keypad_debouncer;

  logic       scan_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       keydown = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       held;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;

  keypad_debouncer #(.STABLE_FRAMES(4)) dut (
    .scan_clk (scan_clk),
    .rst_n    (rst_n),
    .keydown  (keydown),
    .key      (key),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key_code (key_code),
    .held     (held),
    .overrun  (overrun)
  );

  always #5 scan_clk = ~scan_clk;

  // Scoreboard: every accepted code must match the next queued press.
  always @(negedge scan_clk) begin
    if (rst_n && key_valid && key_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got code %0d, no press was expected", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          n_fail++;
          $display("FAIL sb_code: got %0d, expected %0d", key_code, exp_code);
        end
      end
    end
  end

  // Drives one cycle of inputs; on return cyc names the cycle whose outputs are now visible.
  task automatic drive(input logic kd, input logic [3:0] k, input logic rdy);
    keydown   = kd;
    key       = k;
    key_ready = rdy;
    @(posedge scan_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    keydown   = 1'b0;
    key       = 4'd0;
    key_ready = 1'b0;
    repeat (2) begin
      @(posedge scan_clk);
      #1;
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({key_valid, held, overrun, key_code} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 0000000", {key_valid, held, overrun, key_code});
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    do_reset();
    exp_q.push_back(4'd5);
    for (int n = 0; n < 64; n++) begin
      drive(n < 32 && n % 4 == 1, 4'd5, 1'b1);
      exp = {cyc == 16, cyc >= 16 && cyc < 48, 1'b0};
      n_checks++;
      if ({key_valid, held, overrun} !== exp) begin
        n_fail++;
        $display("FAIL basic_vho cyc=%0d: got %b, expected %b", cyc, {key_valid, held, overrun}, exp);
      end
      if (cyc == 16) begin
        n_checks++;
        if (key_code !== 4'd5) begin
          n_fail++;
          $display("FAIL basic_code: got %0d, expected 5", key_code);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp;
    logic       present;
    do_reset();
    exp_q.push_back(4'd9);
    for (int n = 0; n < 64; n++) begin
      present = (n < 12 || (n >= 16 && n < 32)) && (n % 4 == 1);
      drive(present, 4'd9, 1'b1);
      exp = {cyc == 32, cyc >= 32 && cyc < 48, 1'b0};
      n_checks++;
      if ({key_valid, held, overrun} !== exp) begin
        n_fail++;
        $display("FAIL bounce_vho cyc=%0d: got %b, expected %b", cyc, {key_valid, held, overrun}, exp);
      end
    end
  endtask

  task automatic test_multi();
    do_reset();
    for (int n = 0; n < 48; n++) begin
      drive(n < 32 && (n % 4 == 1 || n % 4 == 2), (n % 4 == 1) ? 4'd3 : 4'd12, 1'b1);
      n_checks++;
      if ({key_valid, held, overrun} !== 3'b000) begin
        n_fail++;
        $display("FAIL multi_vho cyc=%0d: got %b, expected 000", cyc, {key_valid, held, overrun});
      end
    end
  endtask

  task automatic test_overrun();
    logic [2:0] exp;
    do_reset();
    exp_q.push_back(4'd7);
    for (int n = 0; n < 56; n++) begin
      drive((n < 16 || (n >= 32 && n < 56)) && n % 4 == 1, (n < 32) ? 4'd7 : 4'd2, 1'b0);
      exp = {cyc >= 16, (cyc >= 16 && cyc < 32) || cyc >= 48, cyc == 48};
      n_checks++;
      if ({key_valid, held, overrun} !== exp) begin
        n_fail++;
        $display("FAIL ovr_vho cyc=%0d: got %b, expected %b", cyc, {key_valid, held, overrun}, exp);
      end
      if (cyc >= 16) begin
        n_checks++;
        if (key_code !== 4'd7) begin
          n_fail++;
          $display("FAIL ovr_code cyc=%0d: got %0d, expected 7", cyc, key_code);
        end
      end
    end
    drive(1'b0, 4'd0, 1'b1);
    n_checks++;
    if ({key_valid, overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovr_drain: got %b, expected 00", {key_valid, overrun});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    logic [3:0] exp_c;
    do_reset();
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd8);
    for (int n = 0; n < 56; n++) begin
      drive((n < 16 || (n >= 32 && n < 56)) && n % 4 == 1, (n < 32) ? 4'd4 : 4'd8, n == 47);
      exp = {cyc >= 16, (cyc >= 16 && cyc < 32) || cyc >= 48, 1'b0};
      n_checks++;
      if ({key_valid, held, overrun} !== exp) begin
        n_fail++;
        $display("FAIL b2b_vho cyc=%0d: got %b, expected %b", cyc, {key_valid, held, overrun}, exp);
      end
      if (cyc >= 16) begin
        exp_c = (cyc >= 48) ? 4'd8 : 4'd4;
        n_checks++;
        if (key_code !== exp_c) begin
          n_fail++;
          $display("FAIL b2b_code cyc=%0d: got %0d, expected %0d", cyc, key_code, exp_c);
        end
      end
    end
    drive(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b, expected 0", key_valid);
    end
  endtask

  task automatic test_reset_held();
    logic [2:0] exp;
    do_reset();
    exp_q.push_back(4'd6);
    for (int n = 0; n < 20; n++) begin
      drive(n % 4 == 1, 4'd6, 1'b0);
    end
    n_checks++;
    if ({key_valid, held} !== 2'b11) begin
      n_fail++;
      $display("FAIL rh_pre: got %b, expected 11", {key_valid, held});
    end
    rst_n = 1'b0;
    drive(1'b0, 4'd6, 1'b0);
    n_checks++;
    if ({key_valid, held, overrun, key_code} !== 7'd0) begin
      n_fail++;
      $display("FAIL rh_reset: got %b, expected 0000000", {key_valid, held, overrun, key_code});
    end
    void'(exp_q.pop_front());
    exp_q.push_back(4'd6);
    rst_n = 1'b1;
    cyc   = 0;
    for (int n = 0; n < 24; n++) begin
      drive(n % 4 == 1, 4'd6, 1'b0);
      exp = {cyc >= 16, cyc >= 16, 1'b0};
      n_checks++;
      if ({key_valid, held, overrun} !== exp) begin
        n_fail++;
        $display("FAIL rh_vho cyc=%0d: got %b, expected %b", cyc, {key_valid, held, overrun}, exp);
      end
    end
    drive(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rh_drain: got %b, expected 0", key_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_reset_held();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d presses never delivered, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_debouncer.md
# keypad_debouncer

Downstream consumer of the 4×4 keypad scanner. Samples the scanner's per-column `keydown`/`key` outputs on the scan clock and groups them into 4-cycle scan frames. A key code counts as pressed only after it persists for `STABLE_FRAMES` consecutive frames. Each debounced press is delivered exactly once through a single-entry valid/ready output register.

## Interface
- `STABLE_FRAMES`, default 4: consecutive identical frames needed to accept a press, and empty frames needed to accept a release. Legal range 2..15.
- `scan_clk`  in  1  scan clock, the same clock that drives the keypad scanner.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `keydown`  in  1  scanner raw "a row is low in the current column" flag.
- `key`  in  4  scanner raw key code, meaningful only while `keydown`=1.
- `key_ready`  in  1  consumer accepts `key_code` this cycle.
- `key_valid`  out  1  a debounced press is pending.
- `key_code`  out  4  code of the pending press, held stable while `key_valid`=1.
- `held`  out  1  debounced key-down level (states HELD and RELEASE).
- `overrun`  out  1  one-cycle pulse: a press was dropped because the output register was full.

## Operation
- Frame counter: 2-bit, free-running, 0 after reset. A frame is counter values 0..3. Any 4 consecutive cycles cover all four scanner columns, so alignment to the scanner's column counter is irrelevant.
- Frame accumulation: `f_hit`, `f_code`, `f_multi`, all cleared at each frame start.
  - First cycle in the frame with `keydown`=1: sets `f_hit`, latches `f_code`=`key`.
  - A later `keydown` cycle with a different `key`: sets `f_multi`.
  - The cycle at counter 3 contributes its own sample before evaluation.
- Frame result at end of frame (counter 3):
  - NONE if no hit.
  - MULTI if `f_multi`.
  - KEY(c) otherwise.
- FSM, evaluated only at end of frame. States: IDLE, CONFIRM, HELD, RELEASE. The 4-bit frame count `cnt` uses saturating-free arithmetic, since it never exceeds `STABLE_FRAMES`.
  - IDLE: KEY(c) → CONFIRM, `cand`=c, `cnt`=1. NONE/MULTI → stay.
  - CONFIRM: KEY(`cand`) → `cnt`+1. If `cnt`+1 == `STABLE_FRAMES`: issue press(`cand`) and go to HELD.
  - CONFIRM: KEY(c≠`cand`) → restart, `cand`=c, `cnt`=1. NONE or MULTI → IDLE.
  - HELD: NONE → RELEASE, `cnt`=1. KEY or MULTI → stay. Holding a key never produces repeats.
  - RELEASE: NONE → `cnt`+1. If `cnt`+1 == `STABLE_FRAMES` → IDLE. KEY or MULTI → HELD, no new press.
- Output register, single entry:
  - On a press: if `key_valid`=0, or `key_valid`=1 and `key_ready`=1 in the same cycle, load `key_code` and keep or set `key_valid`=1.
  - On a press with `key_valid`=1 and `key_ready`=0: drop the new press, keep the old code, assert `overrun` for one cycle.
  - `key_ready` with `key_valid`=1 and no press: clear `key_valid` next cycle.
  - `key_ready` while `key_valid`=0: ignored.

## Timing
- Reset (`rst_n`=0 at a `scan_clk` edge) forces the following next cycle, regardless of the current state, including mid-press or while `key_valid` is pending (the pending code is discarded):
  - `key_valid`=0, `key_code`=0, `held`=0, `overrun`=0.
  - FSM=IDLE, `cnt`=0, frame counter=0, accumulators cleared.
- Define cycle 0 as the first edge with `rst_n`=1. Frame k spans cycles 4k..4k+3.
- Press latency: a key first visible in frame k is issued at the edge of cycle 4(k+`STABLE_FRAMES`−1)+3. `key_valid` and `held` read 1 from the following cycle.
- Release latency: `held` falls after the `STABLE_FRAMES`-th consecutive empty frame ends.
- `overrun` is registered and high for exactly one cycle per dropped press.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- `STABLE_FRAMES`=4. From cycle 0, drive `keydown`=1, `key`=5 on cycles ≡1 mod 4 for 32 cycles, with `key_ready`=1 → one `key_valid` pulse with `key_code`=5, visible at cycle 16. `held`=1 from cycle 16 and falls at cycle 48.
- Bounce: key 9 present in frames 0, 1, 2, absent in frame 3, then present in frames 4–7 → no event before frame 7 ends, a single press of 9 after cycle 31, and no second event.
- Two keys (3 and 12) in the same frames → MULTI every frame, no press, `held`=0.
- Hold `key_ready`=0. Press 7 and release it, then press 2 → `key_valid`=1 with `key_code`=7 throughout, one `overrun` pulse when 2 is issued. Then `key_ready`=1 for one cycle → `key_valid`=0.
- Press/accept in the same cycle: `key_valid`=1 holding code 4, `key_ready`=1 on the cycle press(8) issues → `key_code`=8, `key_valid` stays 1, no `overrun`.
- Assert `rst_n`=0 for one cycle while in HELD with `key_valid`=1 → all outputs 0 next cycle. With the key still down, a new press requires a full `STABLE_FRAMES` confirm.
